ccff_loader: RTL

Configuration-chain loader that drives the serial `ccff_head` input of a tile's configuration flip-flop chain and monitors its `ccff_tail` output. It accepts bitstream words over a valid/ready stream, serializes them MSB-first, and gates chain shifting through a clock-enable. In verify mode it streams the bitstream a second time and checks that `ccff_tail` echoes the first pass bit-for-bit. It sits between the bitstream source and the top-level chain head and tail, e.g. an 8-subtile IO row.

---
 rtl/ccff_pkg.sv | 17 +
 rtl/ccff_serializer.sv | 71 +++++++
 rtl/ccff_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

    // Session phases of the loader.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } ccff_state_t;

    // Number of stream words needed to cover one pass over the chain.
    function automatic int ccff_words_per_pass(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/ccff_serializer.sv
// One-word shift register with a valid/ready front end. A word is loaded
// together with the number of its upper bits that are meaningful; bits are
// presented MSB-first, one per cycle, with no stall once loaded.
module ccff_serializer
    import ccff_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int BIT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_ok_i,    // the session still needs words
    input  logic [WORD_W-1:0] s_data_i,
    input  logic              s_valid_i,
    input  logic [BIT_W-1:0]  load_bits_i,  // meaningful bits of the next word
    output logic              s_ready_o,
    output logic              accept_o,
    output logic              bit_o,        // serial bit, registered
    output logic              bit_vld_o,    // bit_o is being shifted this cycle
    output logic              bit_last_o    // this is the word's final bit
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [BIT_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic              last;

    assign last      = vld_q && (cnt_q == BIT_W'(1));
    // Accepting while the last bit leaves keeps the stream gap-free.
    assign s_ready_o = load_ok_i && (!vld_q || last);
    assign accept_o  = s_ready_o && s_valid_i;

    assign bit_o      = word_q[WORD_W-1];
    assign bit_vld_o  = vld_q;
    assign bit_last_o = last;

    // Next word/count: load on handshake, otherwise shift out one bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        word_d = word_q;
        cnt_d  = cnt_q;
        if (accept_o) begin
            word_d = s_data_i;
            cnt_d  = load_bits_i;
        end else if (last) begin
            // Discarded low bits are cleared so the head idles at 0.
            word_d = '0;
            cnt_d  = '0;
        end else if (vld_q) begin
            word_d = word_q << 1;
            cnt_d  = cnt_q - BIT_W'(1);
        end
        vld_d = (cnt_d != '0);
    end

    // Word register, bit counter and registered bit-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the word register is reset too; it drives a chip-level output that must read 0 in reset.
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
            word_q <= word_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams bitstream words MSB-first into the
// chain head, gates chain shifting, and optionally replays the bitstream
// while checking that the chain tail echoes the first pass.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  err_idx
);

    localparam int WPP   = ccff_words_per_pass(CHAIN_LEN, WORD_W);
    localparam int WC_W  = $clog2(WPP + 1);
    localparam int REM   = CHAIN_LEN % WORD_W;
    localparam int BIT_W = $clog2(WORD_W + 1);

    localparam logic [BIT_W-1:0] FULL_BITS = BIT_W'(WORD_W);
    localparam logic [BIT_W-1:0] TAIL_BITS = (REM != 0) ? BIT_W'(REM) : BIT_W'(WORD_W);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0]  WPP_CNT   = WC_W'(WPP);

    ccff_state_t       state_q, state_d;
    logic              verify_q, verify_d;
    logic              pend_q, pend_d;      // a second pass of words is still to be accepted
    logic [WC_W-1:0]   words_q, words_d;    // words left to accept in the current pass
    logic [CNT_W-1:0]  pass_q, pass_d;      // bit index within the pass being shifted
    logic              error_q, error_d;
    logic [CNT_W-1:0]  err_idx_q, err_idx_d;

    logic              active;
    logic              load_ok;
    logic [BIT_W-1:0]  load_bits;
    logic              accept;
    logic              ser_bit;
    logic              ser_vld;
    logic              ser_last;
    logic              pass_end;

    assign active    = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
    assign load_ok   = active && (words_q != '0);
    assign load_bits = (words_q == WC_W'(1)) ? TAIL_BITS : FULL_BITS;
    // Words never straddle passes, so a pass always ends on a word's last bit.
    assign pass_end  = ser_last && (pass_q == LAST_IDX);

    ccff_serializer #(
        .WORD_W (WORD_W),
        .BIT_W  (BIT_W)
    ) u_ser (
        .clk         (prog_clk),
        .rst_n       (prog_rst_n),
        .load_ok_i   (load_ok),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .load_bits_i (load_bits),
        .s_ready_o   (s_ready),
        .accept_o    (accept),
        .bit_o       (ser_bit),
        .bit_vld_o   (ser_vld),
        .bit_last_o  (ser_last)
    );

    // Session state sequencing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   if (pass_end) state_d = verify_q ? ST_VERIFY : ST_DONE;
            ST_VERIFY: if (pass_end) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pass bookkeeping and verify comparator.
    always_comb begin
        verify_d  = verify_q;
        pend_d    = pend_q;
        words_d   = words_q;
        pass_d    = pass_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        if ((state_q == ST_IDLE) && start) begin
            verify_d  = verify;
            pend_d    = verify;
            words_d   = WPP_CNT;
            pass_d    = '0;
            error_d   = 1'b0;
            err_idx_d = '0;
        end else begin
            if (accept) begin
                if ((words_q == WC_W'(1)) && pend_q) begin
                    words_d = WPP_CNT;
                    pend_d  = 1'b0;
                end else begin
                    words_d = words_q - WC_W'(1);
                end
            end
            if (ser_vld) begin
                pass_d = pass_end ? '0 : pass_q + CNT_W'(1);
            end
            // Only the first mismatch of a session records its index.
            if ((state_q == ST_VERIFY) && ser_vld && (ccff_tail != ser_bit) && !error_q) begin
                error_d   = 1'b1;
                err_idx_d = pass_q;
            end
        end
    end

    // State register.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pass counters and verify status registers.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            verify_q  <= 1'b0;
            pend_q    <= 1'b0;
            words_q   <= '0;
            pass_q    <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            verify_q  <= verify_d;
            pend_q    <= pend_d;
            words_q   <= words_d;
            pass_q    <= pass_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign ccff_head   = ser_bit;
    assign prog_clk_en = ser_vld;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign err_idx     = err_idx_q;

endmodule
